// File: rtl/pc_stall_ctrl.sv
// pc_stall_ctrl: D-stage hazard detect, stall/flush control, mult/div busy sequencer.
// Optional STALL_PERF_EN adds a 32-bit stall cycle counter on port stall_count.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   d_rs, d_rt          D-stage source registers
//   d_use_rs/rt         D reads rs/rt (in D or E)
//   d_branch_rs/rt      D needs rs/rt already in D (branch compare, jr)
//   d_md_op             D is mult/div/mfhi/mflo/mthi/mtlo
//   e_wa, e_mem_read,
//   e_reg_write         E-stage destination, load flag, GPR write flag
//   m_wa, m_mem_read    M-stage destination and load flag
//   e_md_start, e_md_div
//                       E starts mult (div=0) or div (div=1)
//   stall               hold PC and F/D (active-low PC enable)
//   flush_de            clear D/E
//   md_busy             mult/div unit occupied
//   stall_count         stalled cycles (STALL_PERF_EN only)
module pc_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic       d_branch_rs,
  input  logic       d_branch_rt,
  input  logic       d_md_op,
  input  logic [4:0] e_wa,
  input  logic       e_mem_read,
  input  logic       e_reg_write,
  input  logic [4:0] m_wa,
  input  logic       m_mem_read,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       stall,
  output logic       flush_de,
  output logic       md_busy
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic e_hit_rs, e_hit_rt;
  logic m_hit_rs, m_hit_rt;
  logic hz_load_use, hz_br_e, hz_br_m, hz_md;
  logic busy;

  // Register 0 is hard-wired zero and never a real producer.
  assign e_hit_rs = (e_wa != 5'd0) && (e_wa == d_rs);
  assign e_hit_rt = (e_wa != 5'd0) && (e_wa == d_rt);
  assign m_hit_rs = (m_wa != 5'd0) && (m_wa == d_rs);
  assign m_hit_rt = (m_wa != 5'd0) && (m_wa == d_rt);

  assign hz_load_use = e_mem_read &&
                       ((d_use_rs && e_hit_rs) ||
                        (d_use_rt && e_hit_rt));

  // Any E-stage result is too late for a D-stage compare.
  assign hz_br_e = e_reg_write &&
                   ((d_branch_rs && e_hit_rs) ||
                    (d_branch_rt && e_hit_rt));

  // Load data in M is not yet available to D.
  assign hz_br_m = m_mem_read &&
                   ((d_branch_rs && m_hit_rs) ||
                    (d_branch_rt && m_hit_rt));

  assign busy  = (state_q == BUSY);
  assign hz_md = d_md_op && (busy || e_md_start);

  assign stall    = !rst &&
                    (hz_load_use || hz_br_e ||
                     hz_br_m || hz_md);
  assign flush_de = stall;
  assign md_busy  = !rst && busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (e_md_start) begin
          state_d = BUSY;
          cnt_d   = e_md_div ? DIV_LD : MULT_LD;
        end
      end
      BUSY: begin
        // A start seen here cannot be legal; it is dropped.
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Natural 32-bit wrap from all-ones to zero.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/pc_stall_ctrl.md
# pc_stall_ctrl

Hazard and stall controller for the five-stage pipeline. It drives the PC register's hold input and the F/D and D/E pipeline registers. It detects load-use and branch-operand hazards in the D stage, and runs the multi-cycle multiply/divide busy sequencer. Stall priority is resolved here, so the PC, F/D and D/E registers stay plain enable/clear registers.

## Interface
Parameters:
- MULT_CYCLES, 5, E-stage busy cycles for mult/multu after start
- DIV_CYCLES, 10, busy cycles for div/divu after start

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- d_rs, d_rt  in  5  source register numbers of the instruction in D
- d_use_rs, d_use_rt  in  1  D instruction reads rs / rt in D (branch, jr) or in E (ALU)
- d_branch_rs, d_branch_rt  in  1  D instruction needs rs / rt in D (branch compare, jr/jalr)
- d_md_op  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_wa  in  5  destination register of E instruction (0 = none)
- e_mem_read  in  1  E instruction is a load
- e_reg_write  in  1  E instruction writes a GPR
- m_wa  in  5  destination register of M instruction
- m_mem_read  in  1  M instruction is a load
- e_md_start  in  1  E instruction starts mult/div this cycle
- e_md_div  in  1  qualifies e_md_start: 1 = divide, 0 = multiply
- stall  out  1  1 = hold PC and F/D; drives the PC register's active-low enable input directly
- flush_de  out  1  synchronous clear of D/E (bubble insert)
- md_busy  out  1  mult/div unit occupied
- stall_count  out  32  cycles with stall=1 (only with STALL_PERF_EN)

## Operation
- Register 0 never causes a hazard. Every compare on e_wa/m_wa also requires wa != 0.
- Load-use: e_mem_read && e_wa matches (d_use_rs && d_rs) or (d_use_rt && d_rt).
- Branch-E: e_reg_write && e_wa matches a register flagged by d_branch_rs/rt. The ALU result is not forwardable to D.
- Branch-M: m_mem_read && m_wa matches a register flagged by d_branch_rs/rt.
- MD hazard: d_md_op && (md_busy || e_md_start).
- stall = OR of the four hazards. flush_de = stall.
- The PC applies the branch target only when stall=0, so a stalled branch redirects on the cycle its hazard clears.
- MD FSM:
  - States: IDLE, BUSY. Down-counter cnt, width fits DIV_CYCLES.
  - IDLE, e_md_start=1: go to BUSY; cnt = DIV_CYCLES if e_md_div, else MULT_CYCLES.
  - BUSY: cnt decrements each cycle. On cnt==1, return to IDLE next edge.
  - e_md_start while BUSY is ignored. The FSM is not restarted and cnt is not reloaded. This case is illegal by construction, because the MD hazard stalls it.
- md_busy = (state==BUSY).
- Reset, including mid-operation: state=IDLE, cnt=0, stall_count=0.
- During rst: stall=0, flush_de=0, md_busy=0.

## Timing
- Hazard outputs are combinational from inputs and state in the same cycle. There are no registered outputs except md_busy.
- Load-use costs exactly 1 stall cycle.
- Branch-E costs 1 stall cycle, or 2 if the E instruction is a load (branch-E, then branch-M).
- mult issued in E at edge T: md_busy=1 for cycles T+1 .. T+MULT_CYCLES, 0 at T+MULT_CYCLES+1.
- A dependent mfhi in D at T stalls through T+MULT_CYCLES and proceeds at T+MULT_CYCLES+1.
- Simultaneous hazards: any one is sufficient. Stall length is set by the longest outstanding cause; they are not added.
- stall_count increments on each rising edge where stall=1 and rst=0. It wraps 0xFFFF_FFFF to 0.

## Configuration
- STALL_PERF_EN defined: the 32-bit stall_count register and port are present.
- STALL_PERF_EN undefined: the stall_count port and register are absent. All other behaviour is identical.

## Test plan
- Load-use: lw $1 in E, D = add $2,$1,$3. Expect stall=1 and flush_de=1 for exactly 1 cycle; PC holds 0x0000_3004 for that cycle; stall_count=1.
- $0 filter: lw $0 in E, D reads $0. Expect stall=0.
- Branch after load: lw $4 in E, D = beq $4,$5. Expect stall=1 for 2 consecutive cycles; PC loads the branch target on the third cycle.
- Multiply: e_md_start=1, e_md_div=0 at edge T, mflo in D from T+1. Expect md_busy high for 5 cycles and stall high through T+5; mflo leaves D at T+6.
- Divide with mid-operation reset: start a div, assert rst at busy cycle 4. Expect md_busy=0, stall=0 and stall_count=0 on the next edge; a new mult then gives 5 busy cycles.
- Counter wrap (STALL_PERF_EN): preload the count to 0xFFFF_FFFF via force, stall 1 cycle. Expect stall_count=0.
